deparser_layer: RTL

- Reverse of the per-layer parser: writes up to FIELD_NUM (possibly modified) key fields from metadata back into the packet header at configured 16-bit-granular offsets.
- One instance per protocol layer in the deparser chain, mirroring the parser pipeline order.
- Two-stage valid/ready pipeline with a per-field rule configuration bus and statistics counters.

---
 rtl/deparser_pkg.sv | 21 ++
 rtl/deparser_layer_insert_field.sv | 26 ++
 rtl/deparser_layer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/deparser_pkg.sv
// Shared types and constants for the per-layer deparser.
// Covers the field-config record, the config address map and the readback packing.
package deparser_pkg;

    localparam int FIELD_W   = 16;
    localparam int FIELD_NUM = 4;
    localparam int CANDI_NUM = 32;

    localparam logic [3:0] ADDR_PKT_CNT = 4'd8;
    localparam logic [3:0] ADDR_OOR_CNT = 4'd9;

    typedef struct packed {
        logic       en;
        logic [7:0] off;
    } field_cfg_t;

    function automatic logic [31:0] cfg_to_word(input field_cfg_t c);
        return {c.en, 23'd0, c.off};
    endfunction

endpackage

// File: rtl/deparser_layer_insert_field.sv
// Combinational overwrite of one 16-bit candidate slot with a key field.
// Slot 0 sits at the MSBs; offsets past the last slot leave the header untouched.
module insert_field
    import deparser_pkg::*;
#(
    parameter int HEAD_WIDTH = 512,
    parameter int SLOT_W     = 16,
    parameter int SLOT_NUM   = 32
) (
    input  logic [HEAD_WIDTH-1:0] i_head,
    input  logic [SLOT_W-1:0]     i_field,
    input  logic [7:0]            i_off,
    input  logic                  i_en,
    output logic [HEAD_WIDTH-1:0] o_head
);

    always_comb begin
        o_head = i_head;
        for (int s = 0; s < SLOT_NUM; s++) begin
            if (i_en && (int'(i_off) == s)) begin
                o_head[(SLOT_NUM-1-s)*SLOT_W +: SLOT_W] = i_field;
            end
        end
    end

endmodule

// File: rtl/deparser_layer.sv
// Per-layer deparser: writes metadata key fields back into header slots.
// Two-stage valid/ready pipeline, per-field rule registers and packet/out-of-range counters.
module deparser_layer #(
    parameter int HEAD_WIDTH = 512,
    parameter int FIELD_W    = deparser_pkg::FIELD_W,
    parameter int FIELD_NUM  = deparser_pkg::FIELD_NUM,
    parameter int CANDI_NUM  = HEAD_WIDTH / FIELD_W,
    parameter int META_WIDTH = FIELD_NUM * FIELD_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_rule_wren,
    input  logic                  i_rule_rden,
    input  logic [31:0]           i_rule_addr,
    input  logic [31:0]           i_rule_wdata,
    output logic                  o_rule_rdata_valid,
    output logic [31:0]           o_rule_rdata,
    input  logic                  i_head_valid,
    output logic                  o_head_ready,
    input  logic [HEAD_WIDTH-1:0] i_head,
    input  logic [META_WIDTH-1:0] i_meta,
    output logic                  o_head_valid,
    input  logic                  i_head_ready,
    output logic [HEAD_WIDTH-1:0] o_head
);
    import deparser_pkg::*;

    field_cfg_t            r_cfg    [FIELD_NUM];
    field_cfg_t            r_s1_cfg [FIELD_NUM];
    logic                  r_s1_valid;
    logic [HEAD_WIDTH-1:0] r_s1_head;
    logic [META_WIDTH-1:0] r_s1_meta;
    logic                  r_s2_valid;
    logic [HEAD_WIDTH-1:0] r_s2_head;
    logic [31:0]           r_pkt_cnt;
    logic [15:0]           r_oor_cnt;
    logic                  r_rdata_valid;
    logic [31:0]           r_rdata;

    logic [3:0]            w_addr;
    logic                  w_unused_bits;
    logic                  w_accept;
    logic                  w_s1_advance;
    logic                  w_s2_fire;
    logic                  w_oor_any;
    logic [31:0]           w_rd_word;
    logic [HEAD_WIDTH-1:0] w_chain [FIELD_NUM+1];

    assign w_addr        = i_rule_addr[3:0];
    assign w_unused_bits = ^{i_rule_addr[31:4], i_rule_wdata[30:8]};

    assign w_s1_advance = r_s1_valid && (!r_s2_valid || i_head_ready);
    assign o_head_ready = !r_s1_valid || w_s1_advance;
    assign w_accept     = i_head_valid && o_head_ready;
    assign w_s2_fire    = r_s2_valid && i_head_ready;

    assign o_head_valid       = r_s2_valid;
    assign o_head             = r_s2_head;
    assign o_rule_rdata_valid = r_rdata_valid;
    assign o_rule_rdata       = r_rdata;

    // Rewrite chain: later instances override earlier ones on overlapping slots.
    assign w_chain[0] = r_s1_head;
    for (genvar k = 0; k < FIELD_NUM; k++) begin : g_insert
        insert_field #(
            .HEAD_WIDTH (HEAD_WIDTH),
            .SLOT_W     (FIELD_W),
            .SLOT_NUM   (CANDI_NUM)
        ) u_insert (
            .i_head  (w_chain[k]),
            .i_field (r_s1_meta[META_WIDTH-1-k*FIELD_W -: FIELD_W]),
            .i_off   (r_s1_cfg[k].off),
            .i_en    (r_s1_cfg[k].en),
            .o_head  (w_chain[k+1])
        );
    end

    always_comb begin
        w_oor_any = 1'b0;
        for (int k = 0; k < FIELD_NUM; k++) begin
            if (r_s1_cfg[k].en && (int'(r_s1_cfg[k].off) >= CANDI_NUM)) begin
                w_oor_any = 1'b1;
            end
        end
    end

    always_comb begin
        w_rd_word = 32'd0;
        for (int k = 0; k < FIELD_NUM; k++) begin
            if (w_addr == 4'(k)) begin
                w_rd_word = cfg_to_word(r_cfg[k]);
            end
        end
        if (w_addr == ADDR_PKT_CNT) begin
            w_rd_word = r_pkt_cnt;
        end
        if (w_addr == ADDR_OOR_CNT) begin
            w_rd_word = {16'd0, r_oor_cnt};
        end
    end

    // Rule registers and readback; a read sees the value before a same-cycle write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < FIELD_NUM; k++) begin
                r_cfg[k] <= '0;
            end
            r_rdata_valid <= 1'b0;
            r_rdata       <= 32'd0;
        end else begin
            if (i_rule_wren) begin
                for (int k = 0; k < FIELD_NUM; k++) begin
                    if (w_addr == 4'(k)) begin
                        r_cfg[k] <= {i_rule_wdata[31], i_rule_wdata[7:0]};
                    end
                end
            end
            r_rdata_valid <= i_rule_rden;
            if (i_rule_rden) begin
                r_rdata <= w_rd_word;
            end
        end
    end

    // Stage 1: capture header, metadata and a snapshot of the rule set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_head  <= '0;
            r_s1_meta  <= '0;
            for (int k = 0; k < FIELD_NUM; k++) begin
                r_s1_cfg[k] <= '0;
            end
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_head  <= i_head;
            r_s1_meta  <= i_meta;
            r_s1_cfg   <= r_cfg;
        end else if (w_s1_advance) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2: output register, held while downstream stalls.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_head  <= '0;
        end else if (w_s1_advance) begin
            r_s2_valid <= 1'b1;
            r_s2_head  <= w_chain[FIELD_NUM];
        end else if (w_s2_fire) begin
            r_s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pkt_cnt <= 32'd0;
            r_oor_cnt <= 16'd0;
        end else begin
            if (w_s2_fire) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
            // A software clear takes priority over a same-cycle increment.
            if (i_rule_wren && (w_addr == ADDR_OOR_CNT)) begin
                r_oor_cnt <= 16'd0;
            end else if (w_s1_advance && w_oor_any && (r_oor_cnt != 16'hFFFF)) begin
                r_oor_cnt <= r_oor_cnt + 16'd1;
            end
        end
    end

endmodule
